// File: rtl/arbitrated_multiplexer_n_to_1.sv
// N-to-1 multiplexer with a single-entry registered output stage.
// Channel choice is either a fixed selector (MODE=0) or round-robin over valid channels (MODE=1).
module arbitrated_multiplexer_n_to_1 #(
  parameter int unsigned N_BITS     = 32,
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned MODE       = 0,
  localparam int unsigned SEL_BITS  = $clog2(N_CHANNELS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SEL_BITS-1:0]            selector_i,
  input  logic [N_CHANNELS-1:0]          valid_i,
  input  logic [N_CHANNELS*N_BITS-1:0]   data_i,
  output logic [N_CHANNELS-1:0]          ready_o,
  input  logic                           flush_i,
  output logic [N_BITS-1:0]              mux_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [SEL_BITS-1:0]            grant_o
);

  logic [N_BITS-1:0]   chan_data [N_CHANNELS];

  logic                load_en_c;
  logic                chosen_ok_c;
  logic [SEL_BITS-1:0] chosen_idx_c;
  logic                xfer_c;

  logic                valid_q, valid_d;
  logic [N_BITS-1:0]   mux_q, mux_d;
  logic [SEL_BITS-1:0] grant_q, grant_d;
  logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d;

  // Unpack the flat data bus into per-channel words.
  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_unpack
    assign chan_data[c] = data_i[c*N_BITS +: N_BITS];
  end

  // Output register can take a word when empty or being drained; reset and flush block it.
  assign load_en_c = !reset && !flush_i && (!valid_q || ready_i);

  // Channel choice; the fixed path never looks at valid_i so ready_o stays valid-independent.
  always_comb begin : choose_channel
    int unsigned cand;
    chosen_ok_c  = 1'b0;
    chosen_idx_c = '0;
    cand         = 0;
    if (MODE == 0) begin
      chosen_ok_c  = (32'(selector_i) < N_CHANNELS);
      chosen_idx_c = selector_i;
    end else begin
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        cand = 32'(rr_ptr_q) + i;
        if (cand >= N_CHANNELS) begin
          cand = cand - N_CHANNELS;
        end
        if (!chosen_ok_c && valid_i[SEL_BITS'(cand)]) begin
          chosen_ok_c  = 1'b1;
          chosen_idx_c = SEL_BITS'(cand);
        end
      end
    end
  end

  // At most one ready bit, and only when the output register can load.
  always_comb begin : drive_ready
    ready_o = '0;
    if (chosen_ok_c && load_en_c) begin
      ready_o[chosen_idx_c] = 1'b1;
    end
  end

  assign xfer_c = chosen_ok_c && load_en_c && valid_i[chosen_idx_c];

  // Next-state for the output stage and round-robin pointer.
  always_comb begin : next_state
    valid_d  = valid_q;
    mux_d    = mux_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer_c) begin
      valid_d = 1'b1;
      mux_d   = chan_data[chosen_idx_c];
      grant_d = chosen_idx_c;
      if (MODE != 0) begin
        if (32'(chosen_idx_c) == N_CHANNELS - 1) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = chosen_idx_c + SEL_BITS'(1);
        end
      end
    end else if (load_en_c || flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      valid_q  <= 1'b0;
      mux_q    <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      mux_q    <= mux_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign mux_o   = mux_q;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_arbitrated_multiplexer_n_to_1.sv
// Bench for arbitrated_multiplexer_n_to_1: a fixed-select and a round-robin instance share stimulus.
module tb_arbitrated_multiplexer_n_to_1;

  localparam int unsigned NB = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned SB = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [SB-1:0]     selector_i;
  logic [NC-1:0]     valid_i;
  logic [NC*NB-1:0]  data_i;
  logic              flush_i;
  logic              ready_i;
  logic [NB-1:0]     ch_data [NC];

  logic [NC-1:0]     rdy0, rdy1;
  logic [NB-1:0]     mux0, mux1;
  logic              v0, v1;
  logic [SB-1:0]     g0, g1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < NC; c++) data_i[c*NB +: NB] = ch_data[c];
  end

  arbitrated_multiplexer_n_to_1 #(.N_BITS(NB), .N_CHANNELS(NC), .MODE(0)) u_fix (
    .clk(clk), .reset(reset), .selector_i(selector_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(rdy0), .flush_i(flush_i), .mux_o(mux0), .valid_o(v0), .ready_i(ready_i), .grant_o(g0));

  arbitrated_multiplexer_n_to_1 #(.N_BITS(NB), .N_CHANNELS(NC), .MODE(1)) u_rr (
    .clk(clk), .reset(reset), .selector_i(selector_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(rdy1), .flush_i(flush_i), .mux_o(mux1), .valid_o(v1), .ready_i(ready_i), .grant_o(g1));

  typedef struct {
    logic          rst;
    logic          fl;
    logic          rdy;
    logic [SB-1:0] sel;
    logic [NC-1:0] vld;
    logic [NC-1:0] x_rdy0;
    logic [NC-1:0] x_rdy1;
    logic          x_v0;
    logic [SB-1:0] x_g0;
    logic          x_v1;
    logic [SB-1:0] x_g1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic rdy,
                       input logic [SB-1:0] sel, input logic [NC-1:0] vld);
    reset = rst; flush_i = fl; ready_i = rdy; selector_i = sel; valid_i = vld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) ch_data[c] = 32'hCAFE_0000 + 32'(c);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 4'b0000);

    //          rst   fl    rdy   sel   vld      rdy0     rdy1     v0 g0     v1 g1
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, 2'd2};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd2, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 4'b0011, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd3, 4'b0011, 4'b1000, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd1, 4'b1111, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd2, 4'b1111, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd2, 4'b1111, 4'b0100, 4'b1000, 1'b1, 2'd2, 1'b1, 2'd3};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'b1001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1, 2'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'b1001, 4'b0001, 4'b1000, 1'b1, 2'd0, 1'b1, 2'd3};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].rdy, vecs[i].sel, vecs[i].vld);
      #1;
      chk($sformatf("v%0d ready_o fix", i), 64'(rdy0), 64'(vecs[i].x_rdy0));
      chk($sformatf("v%0d ready_o rr", i), 64'(rdy1), 64'(vecs[i].x_rdy1));
      tick();
      chk($sformatf("v%0d valid_o fix", i), 64'(v0), 64'(vecs[i].x_v0));
      chk($sformatf("v%0d grant_o fix", i), 64'(g0), 64'(vecs[i].x_g0));
      chk($sformatf("v%0d valid_o rr", i), 64'(v1), 64'(vecs[i].x_v1));
      chk($sformatf("v%0d grant_o rr", i), 64'(g1), 64'(vecs[i].x_g1));
      if (vecs[i].x_v0) chk($sformatf("v%0d mux_o fix", i), 64'(mux0), 64'(32'hCAFE_0000 + 32'(vecs[i].x_g0)));
      if (vecs[i].x_v1) chk($sformatf("v%0d mux_o rr", i), 64'(mux1), 64'(32'hCAFE_0000 + 32'(vecs[i].x_g1)));
    end

    // Round-robin rotation from reset with all channels valid, including the 3 -> 0 wrap.
    drive(1'b1, 1'b0, 1'b1, 2'd0, 4'b1111);
    tick();
    chk("rst mux_o rr", 64'(mux1), 64'h0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 2'd0, 4'b1111);
      tick();
      chk($sformatf("rot%0d grant_o rr", k), 64'(g1), 64'(k % 4));
      chk($sformatf("rot%0d valid_o rr", k), 64'(v1), 64'h1);
    end

    // Stall with a held word, then drain and reload on the same edge.
    drive(1'b1, 1'b0, 1'b1, 2'd0, 4'b0000);
    tick();
    ch_data[0] = 32'h0000_1111;
    drive(1'b0, 1'b0, 1'b1, 2'd0, 4'b0001);
    tick();
    chk("load mux_o fix", 64'(mux0), 64'h1111);
    chk("load mux_o rr", 64'(mux1), 64'h1111);
    ch_data[0] = 32'hAAAA_0000;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd1, 4'b1111);
      #1;
      chk($sformatf("stall%0d ready_o fix", k), 64'(rdy0), 64'h0);
      chk($sformatf("stall%0d ready_o rr", k), 64'(rdy1), 64'h0);
      tick();
      chk($sformatf("stall%0d mux_o fix", k), 64'(mux0), 64'h1111);
      chk($sformatf("stall%0d mux_o rr", k), 64'(mux1), 64'h1111);
      chk($sformatf("stall%0d valid_o rr", k), 64'(v1), 64'h1);
    end
    ch_data[1] = 32'h0000_2222;
    drive(1'b0, 1'b0, 1'b1, 2'd1, 4'b1111);
    #1;
    chk("drain ready_o fix", 64'(rdy0), 64'b0010);
    chk("drain ready_o rr", 64'(rdy1), 64'b0010);
    tick();
    chk("drain mux_o fix", 64'(mux0), 64'h2222);
    chk("drain mux_o rr", 64'(mux1), 64'h2222);
    chk("drain grant_o rr", 64'(g1), 64'h1);
    chk("drain valid_o rr", 64'(v1), 64'h1);

    // Reset during a stall drops the held word; round-robin restarts at channel 0.
    drive(1'b0, 1'b0, 1'b0, 2'd3, 4'b1111);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd3, 4'b1111);
    #1;
    chk("rst ready_o fix", 64'(rdy0), 64'h0);
    chk("rst ready_o rr", 64'(rdy1), 64'h0);
    tick();
    chk("rst valid_o fix", 64'(v0), 64'h0);
    chk("rst valid_o rr", 64'(v1), 64'h0);
    chk("rst mux_o fix", 64'(mux0), 64'h0);
    chk("rst grant_o rr", 64'(g1), 64'h0);
    drive(1'b0, 1'b0, 1'b1, 2'd3, 4'b1111);
    tick();
    chk("post-rst grant_o rr", 64'(g1), 64'h0);
    chk("post-rst mux_o rr", 64'(mux1), 64'hAAAA_0000);
    chk("post-rst grant_o fix", 64'(g0), 64'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arbitrated_multiplexer_n_to_1.md
ARBITRATED_MULTIPLEXER_N_TO_1 -- requirements
Module: arbitrated_multiplexer_n_to_1

Interface
REQ-001 Parameter N_BITS, default 32: data width per channel (1..64).
REQ-002 Parameter N_CHANNELS, default 4: input channel count (2..16).
REQ-003 Parameter MODE, default 0: 0 = fixed select by selector_i, 1 = round-robin arbitration.
REQ-004 Localparam SEL_BITS = $clog2(N_CHANNELS).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 selector_i  input  SEL_BITS  channel select, used only when MODE=0.
REQ-008 valid_i  input  N_CHANNELS  per-channel data-valid; bit c belongs to channel c.
REQ-009 data_i  input  N_CHANNELS*N_BITS  packed channel data; channel c at bits [c*N_BITS +: N_BITS].
REQ-010 ready_o  output  N_CHANNELS  per-channel accept; combinational.
REQ-011 flush_i  input  1  discards held output and blocks acceptance this cycle.
REQ-012 mux_o  output  N_BITS  registered selected data.
REQ-013 valid_o  output  1  mux_o holds valid data.
REQ-014 ready_i  input  1  downstream accepts mux_o.
REQ-015 grant_o  output  SEL_BITS  channel index of data in mux_o.

Function
REQ-016 Single-entry output register (mux_o, valid_o, grant_o); load_en = !flush_i && (!valid_o || ready_i).
REQ-017 Transfer on channel c occurs in a cycle where valid_i[c] && ready_o[c]; at most one ready_o bit is high per cycle.
REQ-018 MODE=0: chosen = selector_i; ready_o[chosen] = load_en; selector_i >= N_CHANNELS chooses no channel (ready_o all 0).
REQ-019 MODE=1: chosen = first c with valid_i[c] set, scanning from rr_ptr upward modulo N_CHANNELS; ready_o[chosen] = load_en; no valid channel -> ready_o all 0.
REQ-020 MODE=1: ready_o may depend combinationally on valid_i and ready_i; MODE=0: ready_o shall not depend on valid_i.
REQ-021 On transfer from channel c: mux_o <= data of c, grant_o <= c, valid_o <= 1, latency one cycle from transfer to valid_o.
REQ-022 On transfer in MODE=1: rr_ptr <= (c+1) mod N_CHANNELS, wrapping N_CHANNELS-1 -> 0; no transfer -> rr_ptr unchanged.
REQ-023 Load_en high with no transfer: valid_o <= 0 when ready_i consumed it (or it was already 0); mux_o, grant_o hold last value.
REQ-024 valid_o high and ready_i low: mux_o, grant_o, valid_o hold; ready_o all 0 (stall).
REQ-025 Simultaneous ready_i and new transfer: downstream consumes old word and new word loads same edge (full throughput, one word/cycle).
REQ-026 flush_i high: valid_o <= 0 next edge, ready_o all 0, no transfer, rr_ptr unchanged, mux_o/grant_o hold; flush overrides ready_i and valid_i.
REQ-027 Data of a channel is never duplicated or dropped: each transfer produces exactly one valid_o/ready_i handshake unless flushed.

Reset
REQ-028 reset high at a rising edge: valid_o=0, mux_o=0, grant_o=0, rr_ptr=0; reset overrides flush_i and any transfer that edge.
REQ-029 While reset is high ready_o shall be all 0; reset mid-stall discards held word.

Verification
REQ-030 MODE=0, N_CHANNELS=4, selector_i=2, valid_i=4'b0100, data ch2=32'hCAFE_0002, ready_i=1 -> ready_o=4'b0100, next cycle mux_o=32'hCAFE_0002, valid_o=1, grant_o=2.
REQ-031 MODE=1, valid_i=4'b1111 held, ready_i=1 constantly from reset -> grant_o sequence 0,1,2,3,0 on consecutive cycles, rr_ptr wraps 3->0.
REQ-032 MODE=1, rr_ptr=3, valid_i=4'b0011 -> channel 0 granted, rr_ptr becomes 1; next cycle same valid_i -> channel 1 granted.
REQ-033 valid_o=1 with data 32'h1111, ready_i=0 for 3 cycles, valid_i=4'b1111 -> ready_o=0, mux_o stays 32'h1111; ready_i=1 -> new word loads same edge.
REQ-034 valid_o=1, flush_i=1, ready_i=1, valid_i=4'b0001 -> ready_o=0, next cycle valid_o=0, rr_ptr unchanged.
REQ-035 reset asserted while valid_o=1 and ready_i=0 -> next cycle valid_o=0, mux_o=0, grant_o=0; MODE=1 first grant after release from channel 0 upward.
